// File: rtl/rll16_key_loader.sv
// rll16_key_loader: serial, parity-checked, write-once key provisioning for the 16-bit locked core
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_start            one-cycle request to begin a key load
//   key_bit/_valid/_ready serial key stream, LSB first, last beat is even parity
//   relock                clear committed key and return to idle
//   key_out, key_valid    committed key (keyIn_0_i) and its qualifier
//   key_err               last load failed parity
//   busy                  load in progress
module rll16_key_loader #(
  parameter int KEY_W = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  output logic             key_bit_ready,
  input  logic             relock,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);
  localparam int IDX_W = $clog2(KEY_W);
  typedef enum logic [2:0] {IDLE, LOAD, PAR, ARMED, ERROR} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d, key_out_q, key_out_d;
  logic             key_valid_q, key_valid_d, key_err_q, key_err_d;
  logic             accept;
  assign key_bit_ready = state_q == LOAD || state_q == PAR;
  assign busy          = key_bit_ready;
  assign accept        = key_bit_valid && key_bit_ready;
  assign key_out       = key_out_q;
  assign key_valid     = key_valid_q;
  assign key_err       = key_err_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;
    if (relock) begin
      state_d     = IDLE;
      cnt_d       = '0;
      shadow_d    = '0;
      key_out_d   = '0;
      key_valid_d = 1'b0;
      key_err_d   = 1'b0;
    end else if ((state_q == IDLE || state_q == ERROR) && load_start) begin
      state_d   = LOAD;
      cnt_d     = '0;
      shadow_d  = '0;
      key_err_d = 1'b0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_q == LOAD) begin
        shadow_d[cnt_q[IDX_W-1:0]] = key_bit;
        state_d = cnt_q == CNT_W'(KEY_W - 1) ? PAR : LOAD;
      end else if (^shadow_q ^ key_bit) begin
        state_d   = ERROR;
        key_err_d = 1'b1;
      end else begin
        state_d     = ARMED;
        key_out_d   = shadow_q;
        key_valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
    end
  end
endmodule
